// File: rtl/wash_timer.sv
// wash_timer: washing-machine program sequencer counting WASH/RINSE/SPIN/ALARM phases in seconds
module wash_timer #(
  parameter int WASH_T  = 30,
  parameter int RINSE_T = 20,
  parameter int SPIN_T  = 10,
  parameter int ALARM_T = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  input  logic [1:0] mode,
  output logic [2:0] state,
  output logic [7:0] phase_rem,
  output logic [9:0] total_rem,
  output logic       motor_on,
  output logic       water_in,
  output logic       drain,
  output logic       buzzer_en,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, WASH, RINSE, SPIN, ALARM} st_t;
  st_t        r_st, w_st, w_first, w_nxt;
  logic [7:0] r_ph, w_ph;
  logic [9:0] r_tot, w_tot, w_sum;
  logic       w_done, w_tick;
  logic       r_motor, r_water, r_drain, r_buzz, r_done;
  function automatic logic [7:0] plen(input st_t s);
    return s == WASH  ? 8'(WASH_T)  :
           s == RINSE ? 8'(RINSE_T) :
           s == SPIN  ? 8'(SPIN_T)  :
           s == ALARM ? 8'(ALARM_T) : 8'd0;
  endfunction
  assign w_first = mode == 2'b01 ? RINSE : mode == 2'b10 ? SPIN : WASH;
  assign w_sum   = mode == 2'b01 ? 10'(RINSE_T) + 10'(SPIN_T) :
                   mode == 2'b10 ? 10'(SPIN_T) :
                   10'(WASH_T) + 10'(RINSE_T) + 10'(SPIN_T);
  assign w_nxt   = r_st == WASH ? RINSE : r_st == RINSE ? SPIN : r_st == SPIN ? ALARM : IDLE;
  // pause freezes the wash program but never silences the buzzer countdown
  assign w_tick  = sec_tick && r_st != IDLE && (!pause || r_st == ALARM);
  always_comb begin
    w_st   = r_st;
    w_ph   = r_ph;
    w_tot  = r_tot;
    w_done = 1'b0;
    if (cancel) begin
      w_st  = IDLE;
      w_ph  = 8'd0;
      w_tot = 10'd0;
    end else if (r_st == IDLE) begin
      if (start) begin
        w_st  = w_first;
        w_ph  = plen(w_first);
        w_tot = w_sum;
      end
    end else if (w_tick) begin
      if (r_st != ALARM && r_tot != 10'd0) w_tot = r_tot - 10'd1;
      if (r_ph > 8'd1) w_ph = r_ph - 8'd1;
      else begin
        w_st   = w_nxt;
        w_ph   = plen(w_nxt);
        w_done = r_st == SPIN;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st    <= IDLE;
      r_ph    <= 8'd0;
      r_tot   <= 10'd0;
      r_motor <= 1'b0;
      r_water <= 1'b0;
      r_drain <= 1'b0;
      r_buzz  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_st    <= w_st;
      r_ph    <= w_ph;
      r_tot   <= w_tot;
      r_motor <= (w_st == WASH || w_st == RINSE || w_st == SPIN) && !pause;
      r_water <= (w_st == WASH || w_st == RINSE) && !pause;
      r_drain <= w_st == SPIN;
      r_buzz  <= w_st == ALARM;
      r_done  <= w_done;
    end
  end
  assign state     = r_st;
  assign phase_rem = r_ph;
  assign total_rem = r_tot;
  assign motor_on  = r_motor;
  assign water_in  = r_water;
  assign drain     = r_drain;
  assign buzzer_en = r_buzz;
  assign done      = r_done;
endmodule

// File: tb/tb_wash_timer.sv
// tb_wash_timer: vector table, directed corner sequences and random stimulus against a phase-list model
module tb_wash_timer;
  localparam int WT = 30, RT = 20, ST = 10, AT = 5;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sec_tick = 1'b0, start = 1'b0, pause = 1'b0, cancel = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] state;
  logic [7:0] phase_rem;
  logic [9:0] total_rem;
  logic       motor_on, water_in, drain, buzzer_en, done;
  int total = 0, bad = 0;
  int m_st = 0, m_ph = 0, m_done = 0, m_pause = 0;
  wash_timer #(.WASH_T(WT), .RINSE_T(RT), .SPIN_T(ST), .ALARM_T(AT)) dut (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .start(start), .pause(pause),
    .cancel(cancel), .mode(mode), .state(state), .phase_rem(phase_rem),
    .total_rem(total_rem), .motor_on(motor_on), .water_in(water_in), .drain(drain),
    .buzzer_en(buzzer_en), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit st, tk, pa, ca;
    bit [1:0] md;
    int e_st, e_ph, e_tot;
    bit e_m, e_w, e_d, e_b, e_dn;
  } vec_t;
  vec_t tbl[10];
  function automatic int plen(input int s);
    return s == 1 ? WT : s == 2 ? RT : s == 3 ? ST : s == 4 ? AT : 0;
  endfunction
  // remaining cycle time = what is left of this phase plus every later washing phase
  function automatic int exp_tot();
    int t = 0;
    if (m_st >= 1 && m_st <= 3) begin
      t = m_ph;
      for (int k = m_st + 1; k <= 3; k++) t += plen(k);
    end
    return t;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_edge();
    int ps = m_st;
    m_done = 0;
    if (cancel) begin
      m_st = 0;
      m_ph = 0;
    end else if (m_st == 0) begin
      if (start) begin
        m_st = mode == 2'b01 ? 2 : mode == 2'b10 ? 3 : 1;
        m_ph = plen(m_st);
      end
    end else if (sec_tick && (!pause || m_st == 4)) begin
      if (m_ph > 1) m_ph--;
      else begin
        m_st = m_st == 4 ? 0 : m_st + 1;
        m_ph = plen(m_st);
        m_done = int'(ps == 3);
      end
    end
    m_pause = int'(pause);
  endtask
  task automatic model_reset();
    m_st = 0; m_ph = 0; m_done = 0; m_pause = 0;
  endtask
  task automatic compare_all();
    chk("state", state, m_st);
    chk("phase_rem", phase_rem, m_ph);
    chk("total_rem", total_rem, exp_tot());
    chk("motor_on", motor_on, m_st >= 1 && m_st <= 3 && m_pause == 0);
    chk("water_in", water_in, (m_st == 1 || m_st == 2) && m_pause == 0);
    chk("drain", drain, m_st == 3);
    chk("buzzer_en", buzzer_en, m_st == 4);
    chk("done", done, m_done);
  endtask
  task automatic step(input bit cmp);
    @(posedge clk);
    model_edge();
    #1;
    if (cmp) compare_all();
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      sec_tick = 1'b1;
      step(1);
      sec_tick = 1'b0;
      step(1);
    end
  endtask
  task automatic zeros(input string n);
    chk({n, "_state"}, state, 0);
    chk({n, "_phase"}, phase_rem, 0);
    chk({n, "_total"}, total_rem, 0);
    chk({n, "_act"}, {motor_on, water_in, drain, buzzer_en, done}, 0);
  endtask
  initial begin
    int cnt[5];
    int dn_cnt, prev_tot, cyc, ps;
    bit left;
    tbl[0] = '{1, 0, 0, 0, 2'b10, 3, 10, 10, 1, 0, 1, 0, 0};
    tbl[1] = '{0, 1, 0, 0, 2'b10, 3,  9,  9, 1, 0, 1, 0, 0};
    tbl[2] = '{0, 1, 1, 0, 2'b10, 3,  9,  9, 0, 0, 1, 0, 0};
    tbl[3] = '{1, 1, 0, 1, 2'b10, 0,  0,  0, 0, 0, 0, 0, 0};
    tbl[4] = '{1, 1, 0, 0, 2'b01, 2, 20, 30, 1, 1, 0, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 2'b01, 2, 20, 30, 1, 1, 0, 0, 0};
    tbl[6] = '{0, 1, 0, 1, 2'b01, 0,  0,  0, 0, 0, 0, 0, 0};
    tbl[7] = '{1, 0, 0, 0, 2'b11, 1, 30, 60, 1, 1, 0, 0, 0};
    tbl[8] = '{0, 1, 1, 0, 2'b11, 1, 30, 60, 0, 0, 0, 0, 0};
    tbl[9] = '{0, 1, 0, 0, 2'b11, 1, 29, 59, 1, 1, 0, 0, 0};
    @(posedge clk);
    #1;
    zeros("reset");
    rst_n = 1'b1;
    step(1);
    step(1);
    for (int i = 0; i < 10; i++) begin
      start = tbl[i].st; sec_tick = tbl[i].tk; pause = tbl[i].pa; cancel = tbl[i].ca; mode = tbl[i].md;
      step(0);
      chk($sformatf("vec%0d_state", i), state, tbl[i].e_st);
      chk($sformatf("vec%0d_phase", i), phase_rem, tbl[i].e_ph);
      chk($sformatf("vec%0d_total", i), total_rem, tbl[i].e_tot);
      chk($sformatf("vec%0d_act", i), {motor_on, water_in, drain, buzzer_en, done},
          {tbl[i].e_m, tbl[i].e_w, tbl[i].e_d, tbl[i].e_b, tbl[i].e_dn});
    end
    {start, sec_tick, pause} = 3'b000;
    cancel = 1'b1; step(1); cancel = 1'b0;
    // full mode-00 program, one second every ten clocks
    mode = 2'b00; start = 1'b1; step(1); start = 1'b0;
    chk("full_start_total", total_rem, 60);
    cnt = '{0, 0, 0, 0, 0};
    dn_cnt = 0; prev_tot = int'(total_rem); left = 1'b0;
    for (cyc = 0; cyc < 2000 && !left; cyc++) begin
      sec_tick = cyc % 10 == 9;
      ps = int'(state);
      if (sec_tick) cnt[ps]++;
      step(1);
      if (done) dn_cnt++;
      if (int'(total_rem) > prev_tot) chk("total_mono", total_rem, prev_tot);
      prev_tot = int'(total_rem);
      left = state == 3'd0;
    end
    sec_tick = 1'b0;
    if (!left) chk("full_timeout", 1, 0);
    chk("full_wash_ticks", cnt[1], 30);
    chk("full_rinse_ticks", cnt[2], 20);
    chk("full_spin_ticks", cnt[3], 10);
    chk("full_alarm_ticks", cnt[4], 5);
    chk("full_done_pulses", dn_cnt, 1);
    // pause held across ticks in WASH
    mode = 2'b00; start = 1'b1; step(1); start = 1'b0;
    ticks(18);
    chk("pause_pre", phase_rem, 12);
    pause = 1'b1;
    ticks(3);
    chk("pause_hold", phase_rem, 12);
    chk("pause_motor", motor_on, 0);
    chk("pause_water", water_in, 0);
    pause = 1'b0;
    ticks(1);
    chk("pause_release", phase_rem, 11);
    cancel = 1'b1; step(1); cancel = 1'b0;
    // cancel racing the last RINSE second
    mode = 2'b01; start = 1'b1; step(1); start = 1'b0;
    ticks(19);
    chk("cancel_pre", phase_rem, 1);
    cancel = 1'b1; sec_tick = 1'b1; step(1);
    cancel = 1'b0; sec_tick = 1'b0;
    zeros("cancel");
    // start held through ALARM->IDLE restarts one clock later
    mode = 2'b10; start = 1'b1; step(1);
    ticks(14);
    sec_tick = 1'b1; step(1); sec_tick = 1'b0;
    chk("restart_idle", state, 0);
    step(1);
    chk("restart_spin", state, 3);
    start = 1'b0;
    // asynchronous reset mid-SPIN
    ticks(3);
    chk("areset_pre", phase_rem, 7);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 zeros("areset");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1);
    step(1);
    mode = 2'b10; start = 1'b1; step(1); start = 1'b0;
    chk("areset_restart", phase_rem, 10);
    for (int i = 0; i < 4000; i++) begin
      start    = $urandom_range(0, 3) == 0;
      sec_tick = $urandom_range(0, 2) == 0;
      pause    = $urandom_range(0, 7) == 0;
      cancel   = $urandom_range(0, 199) == 0;
      mode     = 2'($urandom_range(0, 3));
      step(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wash_timer.md
WASH_TIMER -- requirements
Module: wash_timer

Interface
REQ-001 Parameter WASH_T, default 30, wash phase length in seconds (1..255).
REQ-002 Parameter RINSE_T, default 20, rinse phase length in seconds (1..255).
REQ-003 Parameter SPIN_T, default 10, spin phase length in seconds (1..255).
REQ-004 Parameter ALARM_T, default 5, end-of-cycle buzzer length in seconds (1..255).
REQ-005 clk  input  1  system clock; the single clock of the block, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 sec_tick  input  1  one-clk-wide pulse, once per second, synchronous to clk.
REQ-008 start  input  1  level; begins a cycle when sampled high in IDLE.
REQ-009 pause  input  1  level; freezes countdown while high.
REQ-010 cancel  input  1  level; aborts to IDLE.
REQ-011 mode  input  2  program select: 00 wash+rinse+spin, 01 rinse+spin, 10 spin only, 11 same as 00.
REQ-012 state  output  3  current phase: IDLE=0, WASH=1, RINSE=2, SPIN=3, ALARM=4.
REQ-013 phase_rem  output  8  seconds remaining in the current phase.
REQ-014 total_rem  output  10  seconds remaining in the whole wash cycle, ALARM excluded.
REQ-015 motor_on, water_in, drain, buzzer_en  output  1 each  actuator enables.
REQ-016 done  output  1  one-clk pulse on entry to ALARM.

Function
REQ-017 All outputs SHALL be registered; each output SHALL change only on a rising clk edge, except during reset.
REQ-018 An accepted tick SHALL be sec_tick=1 with pause=0 and cancel=0 in WASH, RINSE, SPIN or ALARM; pause SHALL NOT suppress ticks in ALARM.
REQ-019 IDLE with start=1 and cancel=0: next edge SHALL enter the first phase of mode and load phase_rem with that phase's length; a sec_tick on the same edge SHALL be ignored.
REQ-020 On that start edge, total_rem SHALL load with the sum of the mode's phases: 60 for mode 00/11, 30 for 01, 10 for 10 at defaults.
REQ-021 On an accepted tick with phase_rem>1: phase_rem and total_rem SHALL each decrement by 1 (total_rem unchanged in ALARM).
REQ-022 On an accepted tick with phase_rem==1: the block SHALL enter the next state and load phase_rem with that state's length.
REQ-023 The next state SHALL follow WASH->RINSE->SPIN->ALARM->IDLE; total_rem SHALL decrement to 0 on the SPIN->ALARM edge.
REQ-024 done SHALL be high for exactly the one clk following the SPIN->ALARM edge.
REQ-025 On the ALARM->IDLE edge, phase_rem and total_rem SHALL be 0.
REQ-026 start SHALL be ignored outside IDLE; holding start high through ALARM->IDLE SHALL begin a new cycle one clk after IDLE is entered.
REQ-027 cancel=1 in any state SHALL force IDLE on the next edge with phase_rem=0, total_rem=0 and all actuators off; cancel SHALL override start, pause and sec_tick on the same edge, and done SHALL NOT assert.
REQ-028 motor_on SHALL be 1 in WASH, RINSE and SPIN when pause=0.
REQ-029 water_in SHALL be 1 in WASH and RINSE when pause=0.
REQ-030 drain SHALL be 1 in SPIN regardless of pause.
REQ-031 buzzer_en SHALL be 1 in ALARM only.
REQ-032 Actuator outputs SHALL reflect the registered state and the pause value sampled at the same edge, i.e. one clk latency from pause.
REQ-033 Counters SHALL never wrap: phase_rem SHALL never go below 1 outside IDLE, and total_rem SHALL never go below 0.

Reset
REQ-034 rst_n=0 SHALL immediately force state=IDLE, phase_rem=0, total_rem=0, and motor_on, water_in, drain, buzzer_en and done all 0, including mid-cycle.
REQ-035 After rst_n rises, the block SHALL remain in IDLE until start is sampled high.

Verification
REQ-036 Mode 00 start, 1 tick per 10 clk, no pause -> WASH 30 ticks, RINSE 20, SPIN 10, done pulse once, ALARM 5 ticks, IDLE; total_rem 60->0 monotonically.
REQ-037 Mode 10 start -> state=SPIN, phase_rem=10, total_rem=10, water_in=0, drain=1, motor_on=1.
REQ-038 WASH at phase_rem=12, pause high across 3 ticks -> phase_rem stays 12, motor_on=0, water_in=0; after release, next tick gives 11.
REQ-039 RINSE at phase_rem=1 with cancel and sec_tick on the same edge -> IDLE, all outputs 0, no done pulse.
REQ-040 start and sec_tick on the same edge in IDLE, mode 01 -> RINSE, phase_rem=20, total_rem=30 (tick not counted).
REQ-041 rst_n pulled low asynchronously mid-SPIN -> outputs 0 before the next clk edge; start after release restarts from the first phase of mode.
